// File: rtl/pfd_loop_filter.sv
// Charge-pump + PI loop filter behind a phase detector: synchronises up/down pulses,
// integrates their net duration into an oscillator tuning word and flags windowed lock.
module pfd_loop_filter #(
   parameter int CTRL_W   = 8,
   parameter int INT_W    = 16,
   parameter int INT_INIT = 32768,
   parameter int KI       = 16,
   parameter int KP       = 4,
   parameter int WIN_LOG2 = 6,
   parameter int LOCK_TOL = 2,
   parameter int LOCK_N   = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              up,
   input  logic              down,
   output logic [CTRL_W-1:0] ctrl_out,
   output logic              locked,
   output logic              sat_hi,
   output logic              sat_lo
);

   localparam int SUM_W  = CTRL_W + 2;
   localparam int NET_W  = WIN_LOG2 + 2;
   localparam int GOOD_W = $clog2(LOCK_N + 1);

   localparam logic [INT_W-1:0]        INT_MAX    = '1;
   localparam logic [INT_W-1:0]        INT_RST    = INT_W'(INT_INIT);
   localparam logic [INT_W-1:0]        KI_V       = INT_W'(KI);
   localparam logic signed [SUM_W-1:0] KP_V       = SUM_W'(KP);
   localparam logic signed [SUM_W-1:0] CTRL_MAX_S = SUM_W'((1 << CTRL_W) - 1);
   localparam logic signed [NET_W-1:0] TOL_V      = NET_W'(LOCK_TOL);
   localparam logic [GOOD_W-1:0]       GOOD_MAX   = GOOD_W'(LOCK_N);
   localparam logic [CTRL_W-1:0]       CTRL_RST   = INT_RST[INT_W-1 -: CTRL_W];

   localparam logic [0:0] ST_ACQ    = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic                     up_meta_q, up_s_q, dn_meta_q, dn_s_q;
   logic [INT_W-1:0]         integ_q, integ_d;
   logic signed [SUM_W-1:0]  prop_q, prop_d;
   logic [CTRL_W-1:0]        ctrl_q, ctrl_d;
   logic                     sat_hi_q, sat_hi_d, sat_lo_q, sat_lo_d;
   logic [WIN_LOG2-1:0]      win_q, win_d;
   logic signed [NET_W-1:0]  net_q, net_d;
   logic [GOOD_W-1:0]        good_q, good_d;
   logic [0:0]               state_q, state_d;

   logic                     err_pos, err_neg, window_good;
   logic signed [SUM_W-1:0]  ctrl_sum;
   logic signed [NET_W-1:0]  err_net, net_sum;

   // Both pulses high (or both low) is a zero phase error.
   assign err_pos = up_s_q & ~dn_s_q;
   assign err_neg = dn_s_q & ~up_s_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      integ_d = integ_q;
      prop_d  = prop_q;
      if (en) begin
         prop_d = '0;
         if (err_pos) begin
            integ_d = (integ_q > INT_MAX - KI_V) ? INT_MAX : integ_q + KI_V;
            prop_d  = KP_V;
         end else if (err_neg) begin
            integ_d = (integ_q < KI_V) ? '0 : integ_q - KI_V;
            prop_d  = -KP_V;
         end
      end
      sat_hi_d = (integ_d == INT_MAX);
      sat_lo_d = (integ_d == '0);
   end

   assign ctrl_sum = $signed({2'b00, integ_q[INT_W-1 -: CTRL_W]}) + prop_q;

   always_comb begin
      ctrl_d = ctrl_q;
      if (en) begin
         if (ctrl_sum < 0)               ctrl_d = '0;
         else if (ctrl_sum > CTRL_MAX_S) ctrl_d = '1;
         else                            ctrl_d = ctrl_sum[CTRL_W-1:0];
      end
   end

   assign err_net     = err_pos ? NET_W'(1) : (err_neg ? '1 : '0);
   assign net_sum     = net_q + err_net;
   assign window_good = (net_sum <= TOL_V) && (net_sum >= -TOL_V);

   // The last cycle of a window is counted before the window is judged.
   always_comb begin
      win_d   = win_q;
      net_d   = net_q;
      good_d  = good_q;
      state_d = state_q;
      if (en) begin
         win_d = win_q + 1'b1;
         net_d = net_sum;
         if (win_q == '1) begin
            net_d = '0;
            if (!window_good) begin
               good_d  = '0;
               state_d = ST_ACQ;
            end else begin
               good_d = (good_q == GOOD_MAX) ? GOOD_MAX : good_q + 1'b1;
               case (state_q)
                  ST_ACQ:    state_d = (good_d == GOOD_MAX) ? ST_LOCKED : ST_ACQ;
                  default:   state_d = ST_LOCKED;
               endcase
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         up_meta_q <= 1'b0;
         up_s_q    <= 1'b0;
         dn_meta_q <= 1'b0;
         dn_s_q    <= 1'b0;
         integ_q   <= INT_RST;
         prop_q    <= '0;
         ctrl_q    <= CTRL_RST;
         sat_hi_q  <= 1'b0;
         sat_lo_q  <= 1'b0;
         win_q     <= '0;
         net_q     <= '0;
         good_q    <= '0;
         state_q   <= ST_ACQ;
      end else begin
         up_meta_q <= up;
         up_s_q    <= up_meta_q;
         dn_meta_q <= down;
         dn_s_q    <= dn_meta_q;
         integ_q   <= integ_d;
         prop_q    <= prop_d;
         ctrl_q    <= ctrl_d;
         sat_hi_q  <= sat_hi_d;
         sat_lo_q  <= sat_lo_d;
         win_q     <= win_d;
         net_q     <= net_d;
         good_q    <= good_d;
         state_q   <= state_d;
      end
   end

   assign ctrl_out = ctrl_q;
   assign locked   = (state_q == ST_LOCKED);
   assign sat_hi   = sat_hi_q;
   assign sat_lo   = sat_lo_q;

endmodule
